// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures a divided clock (clk_meas) against the reference clk_ip.
// It reports the period in clk_ip cycles, a lock flag once the ratio is stable, and a
// timeout pulse when the divided clock stops toggling.
// Optional high-time measurement is enabled by defining the macro DUTY_MEAS_EN; without it
// high_cycles is tied to zero and no high-time counter exists.
module clock_ratio_meter #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic             clk_ip,
  input  logic             rst,
  input  logic             clk_meas,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] high_cycles
);

  localparam int unsigned      MatchW     = 4;
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [MatchW-1:0] LockTarget = MatchW'(LOCK_CNT);
  localparam logic [MatchW-1:0] MatchOne   = MatchW'(1);
  localparam logic              LockOnOne  = (LOCK_CNT == 1);

  typedef enum logic [0:0] {
    StSeek,
    StMeasure
  } state_e;

  // Input synchronizer and edge detector
  logic sync1_q, sync2_q, sync3_q;
  logic rise;

  // Measurement state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic [MatchW-1:0] match_q, match_d;

  // Two-flop synchronizer plus a delay flop for rising-edge detection
  always_ff @(posedge clk_ip) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= clk_meas;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // FSM and measurement registers
  always_ff @(posedge clk_ip) begin
    if (rst) begin
      state_q   <= StSeek;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
      match_q   <= match_d;
    end
  end

  // Next-state: period counting, timeout detection and lock tracking
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    locked_d  = locked_q;
    match_d   = match_q;
    unique case (state_q)
      StSeek: begin
        // First edge only arms the counter; there is no interval to report yet.
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // A rise on the saturating cycle still counts as a valid maximum-length period.
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = CntOne;
          if (match_q == '0) begin
            // First measurement since reset/timeout: nothing to compare against.
            match_d  = MatchOne;
            locked_d = LockOnOne;
          end else if (cnt_q == period_q) begin
            if (match_q < LockTarget) begin
              match_d = match_q + MatchOne;
            end
            if (match_q >= (LockTarget - MatchOne)) begin
              locked_d = 1'b1;
            end
          end else begin
            match_d  = MatchOne;
            locked_d = LockOnOne;
          end
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          cnt_d     = '0;
          state_d   = StSeek;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StSeek;
      end
    endcase
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  // High-time counter register
  always_ff @(posedge clk_ip) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  // Count high cycles within a period; the rise cycle itself is high, so add it at capture
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (state_q == StSeek) begin
      hcnt_d = '0;
    end else if (rise) begin
      hcnt_d = '0;
      if (hcnt_q == CntMax) begin
        high_d = CntMax;
      end else begin
        high_d = hcnt_q + CNT_W'(sync2_q);
      end
    end else if (sync2_q && (hcnt_q != CntMax)) begin
      hcnt_d = hcnt_q + CntOne;
    end
  end

  assign high_cycles = high_q;
`else
  assign high_cycles = '0;
`endif

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter (CNT_W=8, LOCK_CNT=3).
module tb_clock_ratio_meter;

  logic       clk_ip;
  logic       rst;
  logic       clk_meas;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       timeout;
  logic [7:0] high_cycles;

  int checks = 0;
  int errors = 0;

  // Event log filled by the monitor
  int cyc              = 0;
  int valid_cnt        = 0;
  int timeout_cnt      = 0;
  int last_valid_cyc   = 0;
  int last_timeout_cyc = 0;

`ifdef DUTY_MEAS_EN
  localparam int ExpHigh4 = 4;
`else
  localparam int ExpHigh4 = 0;
`endif

  clock_ratio_meter #(
    .CNT_W    (8),
    .LOCK_CNT (3)
  ) dut (
    .clk_ip       (clk_ip),
    .rst          (rst),
    .clk_meas     (clk_meas),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout),
    .high_cycles  (high_cycles)
  );

  initial clk_ip = 1'b0;
  always #5 clk_ip = ~clk_ip;

  always @(posedge clk_ip) cyc <= cyc + 1;

  // Log pulses on the falling edge, away from the active edge
  always @(negedge clk_ip) begin
    if (period_valid === 1'b1) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (timeout === 1'b1) begin
      timeout_cnt      <= timeout_cnt + 1;
      last_timeout_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ip);
    #1;
  endtask

  // One clk_meas period of n reference cycles, high for the first h of them
  task automatic run_period(input int n, input int h);
    for (int i = 0; i < n; i++) begin
      clk_meas = (i < h);
      step();
    end
  endtask

  int vb, tb0;

  initial begin
    rst      = 1'b1;
    clk_meas = 1'b0;
    repeat (3) step();
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_high", int'(high_cycles), 0);
    rst = 1'b0;

    // Divide-by-5: first edge arms, each later edge measures the previous period
    vb  = valid_cnt;
    tb0 = timeout_cnt;
    run_period(5, 2);
    run_period(5, 2);
    chk("div5_first_valid", valid_cnt - vb, 1);
    chk("div5_period", int'(period), 5);
    chk("div5_unlocked1", int'(locked), 0);
    run_period(5, 2);
    chk("div5_unlocked2", int'(locked), 0);
    run_period(5, 2);
    chk("div5_locked3", int'(locked), 1);
    chk("div5_valids", valid_cnt - vb, 3);
    chk("div5_no_timeout", timeout_cnt - tb0, 0);

    // Divide-by-8, a 9-cycle transitional period, then divide-by-10
    run_period(8, 4);
    run_period(8, 4);
    run_period(8, 4);
    run_period(8, 4);
    chk("div8_period", int'(period), 8);
    chk("div8_locked", int'(locked), 1);
    run_period(9, 4);
    chk("div8_still_locked", int'(locked), 1);
    run_period(10, 4);
    chk("trans_period", int'(period), 9);
    chk("trans_unlocked", int'(locked), 0);
    run_period(10, 4);
    chk("div10_period1", int'(period), 10);
    chk("div10_unlocked1", int'(locked), 0);
    run_period(10, 4);
    chk("div10_unlocked2", int'(locked), 0);
    vb  = valid_cnt;
    tb0 = timeout_cnt;
    run_period(10, 4);
    chk("div10_locked", int'(locked), 1);
    chk("div10_period3", int'(period), 10);
    chk("div10_high", int'(high_cycles), ExpHigh4);

    // Stop the divided clock: timeout 255 cycles after the last valid pulse
    clk_meas = 1'b0;
    repeat (300) step();
    chk("to_pulses", timeout_cnt - tb0, 1);
    chk("to_distance", last_timeout_cyc - last_valid_cyc, 255);
    chk("to_unlocked", int'(locked), 0);
    chk("to_period_held", int'(period), 10);
    chk("to_valids", valid_cnt - vb, 1);
    vb = valid_cnt;
    run_period(10, 4);
    chk("to_rearm_no_valid", valid_cnt - vb, 0);
    run_period(10, 4);
    chk("to_rearm_valid", valid_cnt - vb, 1);
    chk("to_rearm_period", int'(period), 10);
    chk("to_rearm_unlocked", int'(locked), 0);
    run_period(10, 4);
    run_period(10, 4);
    chk("relock", int'(locked), 1);

    // Reset mid-measurement while locked
    clk_meas = 1'b1;
    repeat (3) step();
    rst      = 1'b1;
    clk_meas = 1'b0;
    step();
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_valid", int'(period_valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_timeout", int'(timeout), 0);
    chk("mid_rst_high", int'(high_cycles), 0);
    rst = 1'b0;
    vb  = valid_cnt;
    run_period(7, 3);
    chk("post_rst_edge1", valid_cnt - vb, 0);
    run_period(7, 3);
    chk("post_rst_edge2", valid_cnt - vb, 1);
    chk("post_rst_period", int'(period), 7);

    // Edges exactly 255 apart: rise beats the saturation timeout
    vb  = valid_cnt;
    tb0 = timeout_cnt;
    run_period(255, 4);
    chk("max_prev_period", int'(period), 7);
    run_period(255, 4);
    chk("max_period", int'(period), 255);
    chk("max_valids", valid_cnt - vb, 2);
    chk("max_no_timeout", timeout_cnt - tb0, 0);
    chk("max_high", int'(high_cycles), ExpHigh4);
    chk("max_unlocked", int'(locked), 0);
    run_period(255, 4);
    chk("max_period2", int'(period), 255);
    chk("max_no_timeout2", timeout_cnt - tb0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
